// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit mapping byte/half/word requests onto word-only datamem
// Sub-word stores use a read-modify-write pair; misaligned requests are flagged and suppressed.
module mem_access_unit #(
  parameter int ADDR_WORDS = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        dm_MemRead,
  output logic        dm_MemWrite,
  output logic [31:0] dm_Addr,
  output logic [31:0] dm_Wdata,
  input  logic [31:0] dm_Rdata
);

  localparam int IDX_W = $clog2(ADDR_WORDS);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  state_t      state, next_state;
  logic [31:0] merge_q, merge_d;
  logic [31:0] index_q, index_d;

  logic [31:0] word_index;
  logic        active;
  logic        aligned;
  logic        sub_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] extended;
  logic [31:0] merged;
  logic        unused_addr_bits;

  // Upper address bits fall away in the modulo-ADDR_WORDS wrap.
  assign word_index       = {{(32-IDX_W){1'b0}}, addr[IDX_W+1:2]};
  assign unused_addr_bits = ^addr[31:IDX_W+2];

  assign active   = req_read | req_write;
  assign sub_word = (size == 2'b00) || (size == 2'b01);

  always_comb begin
    aligned = 1'b1;
    case (size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    byte_sel = 8'h00;
    case (addr[1:0])
      2'b00: byte_sel = dm_Rdata[31:24];
      2'b01: byte_sel = dm_Rdata[23:16];
      2'b10: byte_sel = dm_Rdata[15:8];
      2'b11: byte_sel = dm_Rdata[7:0];
    endcase
    half_sel = addr[1] ? dm_Rdata[15:0] : dm_Rdata[31:16];
  end

  always_comb begin
    extended = dm_Rdata;
    case (size)
      2'b00:   extended = {{24{~unsigned_ld & byte_sel[7]}}, byte_sel};
      2'b01:   extended = {{16{~unsigned_ld & half_sel[15]}}, half_sel};
      default: extended = dm_Rdata;
    endcase
  end

  always_comb begin
    merged = dm_Rdata;
    if (size == 2'b00) begin
      case (addr[1:0])
        2'b00: merged[31:24] = wdata[7:0];
        2'b01: merged[23:16] = wdata[7:0];
        2'b10: merged[15:8]  = wdata[7:0];
        2'b11: merged[7:0]   = wdata[7:0];
      endcase
    end else if (addr[1]) begin
      merged[15:0] = wdata[15:0];
    end else begin
      merged[31:16] = wdata[15:0];
    end
  end

  always_comb begin
    next_state  = state;
    merge_d     = merge_q;
    index_d     = index_q;
    stall       = 1'b0;
    misaligned  = 1'b0;
    load_data   = 32'h0;
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    dm_Addr     = 32'h0;
    dm_Wdata    = 32'h0;
    case (state)
      IDLE: begin
        if (active) begin
          if (!aligned) begin
            misaligned = 1'b1;
          end else if (req_write && sub_word) begin
            dm_MemRead = 1'b1;
            dm_Addr    = word_index;
            stall      = 1'b1;
            merge_d    = merged;
            index_d    = word_index;
            next_state = RMW_WR;
          end else if (req_write) begin
            dm_MemWrite = 1'b1;
            dm_Addr     = word_index;
            dm_Wdata    = wdata;
          end else begin
            dm_MemRead = 1'b1;
            dm_Addr    = word_index;
            load_data  = extended;
          end
        end
      end
      RMW_WR: begin
        // A reset landing here drops the pending write.
        dm_MemWrite = ~reset;
        dm_Addr     = index_q;
        dm_Wdata    = merge_q;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      merge_q <= 32'h0;
      index_q <= 32'h0;
    end else begin
      state   <= next_state;
      merge_q <= merge_d;
      index_q <= index_d;
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the EX/MEM pipeline register and `datamem`. Turns byte/halfword/word load and store requests into word-only `datamem` accesses, and returns sign- or zero-extended load data to MEM/WB. Sub-word stores use a two-cycle read-modify-write sequence and stall the pipeline for one cycle. Misaligned requests are flagged and suppressed.

## Interface
Parameters:
- `ADDR_WORDS`, 512: depth of `datamem` in words; word index = (addr >> 2) mod `ADDR_WORDS`, power of two.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_read`  in  1  load request from EX/MEM.
- `req_write`  in  1  store request from EX/MEM.
- `size`  in  2  00 byte, 01 halfword, 10 word; 11 treated as word.
- `unsigned_ld`  in  1  1 = zero-extend (lbu/lhu), 0 = sign-extend.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-justified.
- `stall`  out  1  hold EX/MEM and upstream stages this cycle.
- `load_data`  out  32  extended load result to MEM/WB.
- `misaligned`  out  1  pulse: current request is misaligned, access suppressed.
- `dm_MemRead`  out  1  to `datamem` MemRead.
- `dm_MemWrite`  out  1  to `datamem` MemWrite.
- `dm_Addr`  out  32  word index to `datamem` Addr.
- `dm_Wdata`  out  32  to `datamem` Wdata.
- `dm_Rdata`  in  32  from `datamem` Rdata; valid in the same cycle as `dm_MemRead`.

## Operation
- Byte order is big-endian: byte offset 0 = bits [31:24], offset 3 = bits [7:0]; halfword offset 0 = [31:16], offset 2 = [15:0].
- Alignment rules:
  - Halfword requires `addr[0]`=0.
  - Word requires `addr[1:0]`=00.
  - Byte is always aligned.
- Misaligned request:
  - `misaligned`=1 in that cycle.
  - `dm_MemRead`=`dm_MemWrite`=0, `load_data`=0, `stall`=0.
  - No state change.
- If `req_read` and `req_write` are both 1, the write wins and the read is ignored.
- FSM states: IDLE, RMW_WR.
  - **IDLE, load:** `dm_MemRead`=1, `dm_Addr`=word index. `load_data` = selected byte or half of `dm_Rdata`, extended per `unsigned_ld`; for a word load, `load_data` = `dm_Rdata`. No stall; stay in IDLE.
  - **IDLE, word store:**
    - `dm_MemWrite`=1, `dm_Wdata`=`wdata`, no stall.
    - Stay in IDLE.
  - **IDLE, byte/half store:**
    - `dm_MemRead`=1, `stall`=1.
    - On the clock edge, capture the merge word (`dm_Rdata` with the target lane replaced by `wdata[7:0]` or `wdata[15:0]`) and the word index into registers.
    - Go to RMW_WR.
  - **RMW_WR:**
    - `dm_MemWrite`=1, `dm_Addr`=captured index, `dm_Wdata`=captured merge word, `stall`=0.
    - Inputs are ignored this cycle (the request is still held by upstream and retires now).
    - Return to IDLE.
- No request in IDLE: all `dm_*` strobes 0, `dm_Addr`=0, `dm_Wdata`=0, `load_data`=0.

## Timing
- Reset effects:
  - state=IDLE; merge and index registers = 0.
  - Outputs then follow the IDLE rules: `stall`=0, `misaligned`=0, strobes 0.
- Reset asserted while in RMW_WR: the next state is IDLE and the pending write is dropped. During the reset cycle itself, `dm_MemWrite` is forced to 0.
- Load latency: 0 cycles; `load_data` is combinational from `dm_Rdata` and is sampled by MEM/WB at the end of the request cycle.
- Word store: 1 cycle. Sub-word store: 2 cycles, with `stall` high only in the first.
- Upstream must hold `req_*`, `size`, `addr` and `wdata` stable while `stall`=1.
- Address wrap: `addr` ≥ 4·`ADDR_WORDS` wraps modulo `ADDR_WORDS` words; no error is raised.
- Back-to-back operations:
  - A load or store in the cycle after RMW_WR is handled normally from IDLE.
  - A load to the same word immediately after a sub-word store returns the merged value.

## Test plan
- **Word store then word load.** Store 0xDEADBEEF to addr 0x10, then load addr 0x10 → `dm_MemWrite` pulses once with `dm_Addr`=4; the load gives `load_data`=0xDEADBEEF with no stall.
- **Byte store merge.** Preload word 1 = 0x11223344; sb 0xAA at addr 0x05 → cycle 1: `stall`=1, `dm_MemRead`=1; cycle 2: `dm_Wdata`=0x11AA3344, `dm_MemWrite`=1. A following lw at 0x04 returns 0x11AA3344.
- **Load extension.** With word 1 = 0x11AA3344:
  - lb at 0x05 → 0xFFFFFFAA.
  - lbu at 0x05 → 0x000000AA.
  - lh at 0x06 → 0x00003344.
  - sh 0x8001 at 0x04, then lh at 0x04 → 0xFFFF8001.
- **Misaligned requests.** lw at 0x0A, sh at 0x03 → `misaligned`=1 each cycle; no `dm_MemRead`/`dm_MemWrite`; `stall`=0; memory unchanged.
- **Reset during RMW.** sb to 0x08, then assert `reset` in the RMW_WR cycle → no write reaches `datamem`; state IDLE next cycle; word 2 unchanged.
- **Priority and wrap.** `req_read`=`req_write`=1, sw 0x12345678 at 0x800 with `ADDR_WORDS`=512 → write only, `dm_Addr`=0; lw at 0x0 returns 0x12345678.
